// File: rtl/sme_share_bank.sv
// sme_share_bank
//   Holds the non-zero shares (banks 1..SMAX-1) of a masked register file.
//   Share 0 lives in the core GPR file; this block only stores the extra
//   shares, lets the core read/write them alongside the GPRs, streams one
//   register's shares out (store) or in (load), and can zeroise every bank.
//
// Ports
//   g_clk, g_resetn          clock, asynchronous active-low reset
//   g_clk_req                request the clock (activity pending or in progress)
//   smectl_d                 number of shares in use (clamped to SMAX)
//   flush                    abort an in-progress store/load
//   rs1_addr/rs2_addr        combinational read addresses
//   rs1_shares/rs2_shares    read data, bank k in slice k-1
//   rd_wen/rd_addr/rd_wdata  core write port, same slicing
//   xfer_start/dir/addr      start a store (dir=0) or load (dir=1) of one register
//   xfer_busy/xfer_done      transfer/clear active, one-cycle completion pulse
//   st_valid/ready/data/last store stream (bank 1 first)
//   ld_valid/ready/data      load stream (bank 1 first)
//   clr_req/clr_busy         zeroise all banks, one register per cycle
module sme_share_bank #(
    parameter int XLEN = 32,
    parameter int SMAX = 4,
    parameter int NREG = 16,
    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1,
    localparam int SW = (SMAX - 1) * XLEN
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    output logic            g_clk_req,
    input  logic [3:0]      smectl_d,
    input  logic            flush,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [SW-1:0]   rs1_shares,
    output logic [SW-1:0]   rs2_shares,
    input  logic            rd_wen,
    input  logic [AW-1:0]   rd_addr,
    input  logic [SW-1:0]   rd_wdata,
    input  logic            xfer_start,
    input  logic            xfer_dir,
    input  logic [AW-1:0]   xfer_addr,
    output logic            xfer_busy,
    output logic            xfer_done,
    output logic            st_valid,
    input  logic            st_ready,
    output logic [XLEN-1:0] st_data,
    output logic            st_last,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [XLEN-1:0] ld_data,
    input  logic            clr_req,
    output logic            clr_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_STORE = 2'd1,
        S_LOAD  = 2'd2,
        S_CLEAR = 2'd3
    } state_t;

    state_t          r_state;
    logic [3:0]      r_k;       // share index being transferred
    logic [3:0]      r_de;      // share count latched at transfer start
    logic [AW-1:0]   r_addr;    // register being transferred
    logic [AW-1:0]   r_cnt;     // clear sweep counter
    logic            r_done;

    logic [3:0]      w_de;
    logic            w_k_last;
    logic [AW-1:0]   w_wr_addr;
    logic [XLEN-1:0] w_st_word [SMAX-1];
    logic [XLEN-1:0] w_st_data;

    // Effective share count: values above SMAX behave as SMAX.
    assign w_de     = (smectl_d > 4'(SMAX)) ? 4'(SMAX) : smectl_d;
    assign w_k_last = (r_k == (r_de - 4'd1));

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_de    <= '0;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (clr_req) begin
                        r_state <= S_CLEAR;
                        r_cnt   <= '0;
                    end else if (xfer_start) begin
                        if (w_de >= 4'd2) begin
                            r_state <= xfer_dir ? S_LOAD : S_STORE;
                            r_addr  <= xfer_addr;
                            r_de    <= w_de;
                            r_k     <= 4'd1;
                        end else begin
                            // Nothing to move with one share: complete at once.
                            r_done <= 1'b1;
                        end
                    end
                end
                S_STORE: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                        r_k     <= '0;
                    end else if (st_ready) begin
                        if (w_k_last) begin
                            r_state <= S_IDLE;
                            r_k     <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_k <= r_k + 4'd1;
                        end
                    end
                end
                S_LOAD: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                        r_k     <= '0;
                    end else if (ld_valid) begin
                        if (w_k_last) begin
                            r_state <= S_IDLE;
                            r_k     <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_k <= r_k + 4'd1;
                        end
                    end
                end
                S_CLEAR: begin
                    if (r_cnt == AW'(NREG - 1)) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The write sources are exclusive by state, so one shared address suffices.
    always_comb begin
        w_wr_addr = rd_addr;
        case (r_state)
            S_LOAD:  w_wr_addr = r_addr;
            S_CLEAR: w_wr_addr = r_cnt;
            default: w_wr_addr = rd_addr;
        endcase
    end

    generate
        for (genvar gi = 0; gi < SMAX - 1; gi++) begin : g_bank
            logic [XLEN-1:0] r_mem [NREG];
            logic            w_wr_en;
            logic [XLEN-1:0] w_wr_data;

            always_comb begin
                w_wr_en   = 1'b0;
                w_wr_data = rd_wdata[gi*XLEN +: XLEN];
                case (r_state)
                    S_IDLE, S_STORE: begin
                        // Bank gi+1 is active when it is below the share count.
                        w_wr_en = rd_wen && (4'(gi + 1) < w_de);
                    end
                    S_LOAD: begin
                        w_wr_en   = ld_valid && !flush && (r_k == 4'(gi + 1));
                        w_wr_data = ld_data;
                    end
                    S_CLEAR: begin
                        w_wr_en   = 1'b1;
                        w_wr_data = '0;
                    end
                    default: w_wr_en = 1'b0;
                endcase
            end

            // Register-based storage: the bank must clear on asynchronous reset.
            always_ff @(posedge g_clk or negedge g_resetn) begin
                if (!g_resetn) begin
                    for (int i = 0; i < NREG; i++) begin
                        r_mem[i] <= '0;
                    end
                end else if (w_wr_en) begin
                    r_mem[w_wr_addr] <= w_wr_data;
                end
            end

            assign rs1_shares[gi*XLEN +: XLEN] = r_mem[rs1_addr];
            assign rs2_shares[gi*XLEN +: XLEN] = r_mem[rs2_addr];
            assign w_st_word[gi]               = r_mem[r_addr];
        end
    endgenerate

    always_comb begin
        w_st_data = '0;
        for (int b = 1; b < SMAX; b++) begin
            if (st_valid && (r_k == 4'(b))) begin
                w_st_data = w_st_word[b-1];
            end
        end
    end

    assign xfer_busy = (r_state != S_IDLE);
    assign clr_busy  = (r_state == S_CLEAR);
    assign st_valid  = (r_state == S_STORE);
    assign st_last   = st_valid && w_k_last;
    assign st_data   = w_st_data;
    assign ld_ready  = (r_state == S_LOAD);
    assign xfer_done = r_done;
    assign g_clk_req = xfer_busy || rd_wen || xfer_start || clr_req;

endmodule

// File: tb/tb_sme_share_bank.sv
module tb_sme_share_bank;
    localparam int XLEN = 32;
    localparam int SMAX = 4;
    localparam int NREG = 16;
    localparam int SW   = (SMAX - 1) * XLEN;

    logic            g_clk = 1'b0;
    logic            g_resetn = 1'b0;
    logic            g_clk_req;
    logic [3:0]      smectl_d = 4'd4;
    logic            flush = 1'b0;
    logic [3:0]      rs1_addr = '0;
    logic [3:0]      rs2_addr = '0;
    logic [SW-1:0]   rs1_shares;
    logic [SW-1:0]   rs2_shares;
    logic            rd_wen = 1'b0;
    logic [3:0]      rd_addr = '0;
    logic [SW-1:0]   rd_wdata = '0;
    logic            xfer_start = 1'b0;
    logic            xfer_dir = 1'b0;
    logic [3:0]      xfer_addr = '0;
    logic            xfer_busy;
    logic            xfer_done;
    logic            st_valid;
    logic            st_ready = 1'b0;
    logic [XLEN-1:0] st_data;
    logic            st_last;
    logic            ld_valid = 1'b0;
    logic            ld_ready;
    logic [XLEN-1:0] ld_data = '0;
    logic            clr_req = 1'b0;
    logic            clr_busy;

    int checks = 0;
    int failures = 0;

    // Reference contents of banks 1..SMAX-1.
    logic [XLEN-1:0] model [1:SMAX-1][NREG];

    always #5 g_clk = ~g_clk;

    sme_share_bank #(.XLEN(XLEN), .SMAX(SMAX), .NREG(NREG)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn), .g_clk_req(g_clk_req),
        .smectl_d(smectl_d), .flush(flush),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_shares(rs1_shares), .rs2_shares(rs2_shares),
        .rd_wen(rd_wen), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
        .xfer_start(xfer_start), .xfer_dir(xfer_dir), .xfer_addr(xfer_addr),
        .xfer_busy(xfer_busy), .xfer_done(xfer_done),
        .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data), .st_last(st_last),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .clr_req(clr_req), .clr_busy(clr_busy)
    );

    function automatic int eff(input logic [3:0] d);
        return (int'(d) > SMAX) ? SMAX : int'(d);
    endfunction

    function automatic logic [SW-1:0] model_word(input int a);
        logic [SW-1:0] w;
        for (int b = 1; b < SMAX; b++) w[(b-1)*XLEN +: XLEN] = model[b][a];
        return w;
    endfunction

    task automatic model_zero();
        for (int b = 1; b < SMAX; b++)
            for (int a = 0; a < NREG; a++) model[b][a] = '0;
    endtask

    task automatic core_write(input logic [3:0] a, input logic [SW-1:0] data);
        logic [SW-1:0] exp_w;
        @(negedge g_clk);
        rd_wen = 1'b1; rd_addr = a; rd_wdata = data; rs1_addr = a;
        #1;
        exp_w = model_word(int'(a));
        checks++;
        if (rs1_shares !== exp_w) begin
            failures++; $display("FAIL wr_old_value addr=%0d got=%h want=%h", a, rs1_shares, exp_w);
        end
        checks++;
        if (g_clk_req !== 1'b1) begin
            failures++; $display("FAIL clk_req_wen got=%b want=1", g_clk_req);
        end
        @(negedge g_clk);
        rd_wen = 1'b0;
        for (int b = 1; b < SMAX; b++)
            if (b < eff(smectl_d)) model[b][a] = data[(b-1)*XLEN +: XLEN];
        #1;
        exp_w = model_word(int'(a));
        checks++;
        if (rs1_shares !== exp_w) begin
            failures++; $display("FAIL wr_new_value addr=%0d got=%h want=%h", a, rs1_shares, exp_w);
        end
        $display("write addr=%0d d=%0d data=%h", a, smectl_d, data);
    endtask

    task automatic test_readback(input string nm);
        logic [SW-1:0] e1, e2;
        @(negedge g_clk);
        for (int a = 0; a < NREG; a++) begin
            rs1_addr = 4'(a); rs2_addr = 4'(NREG - 1 - a);
            #1;
            e1 = model_word(a); e2 = model_word(NREG - 1 - a);
            checks++;
            if (rs1_shares !== e1) begin
                failures++; $display("FAIL %s rs1 addr=%0d got=%h want=%h", nm, a, rs1_shares, e1);
            end
            checks++;
            if (rs2_shares !== e2) begin
                failures++; $display("FAIL %s rs2 addr=%0d got=%h want=%h", nm, NREG-1-a, rs2_shares, e2);
            end
        end
        $display("readback %s", nm);
    endtask

    task automatic store_xfer(input logic [3:0] a, input bit toggle);
        int de = eff(smectl_d);
        int exp_n = (de >= 2) ? de - 1 : 0;
        int beats = 0;
        int last = -1;
        bit done = 0;
        logic [3:0] saved_d = smectl_d;
        @(negedge g_clk);
        xfer_start = 1'b1; xfer_dir = 1'b0; xfer_addr = a; st_ready = 1'b0;
        @(negedge g_clk);
        xfer_start = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            if (cyc > 0) @(negedge g_clk);
            st_ready = toggle ? cyc[0] : 1'b1;
            if (toggle) smectl_d = 4'($urandom_range(0, 15));
            #1;
            if (xfer_done) begin
                done = 1;
                checks++;
                if (beats != exp_n) begin
                    failures++; $display("FAIL st_beats got=%0d want=%0d", beats, exp_n);
                end
                checks++;
                if (cyc != last + 1) begin
                    failures++; $display("FAIL st_done_latency got=%0d want=%0d", cyc, last + 1);
                end
                checks++;
                if (xfer_busy !== 1'b0) begin
                    failures++; $display("FAIL st_busy_at_done got=%b want=0", xfer_busy);
                end
            end else begin
                checks++;
                if (st_valid !== (beats < exp_n)) begin
                    failures++; $display("FAIL st_valid beat=%0d got=%b want=%b", beats, st_valid, beats < exp_n);
                end
                checks++;
                if (ld_ready !== 1'b0) begin
                    failures++; $display("FAIL ld_ready_in_store got=%b want=0", ld_ready);
                end
                if (st_valid) begin
                    checks++;
                    if (st_data !== model[beats+1][a]) begin
                        failures++; $display("FAIL st_data beat=%0d got=%h want=%h", beats, st_data, model[beats+1][a]);
                    end
                    checks++;
                    if (st_last !== (beats + 1 == de - 1)) begin
                        failures++; $display("FAIL st_last beat=%0d got=%b want=%b", beats, st_last, beats + 1 == de - 1);
                    end
                    if (st_ready) begin beats++; last = cyc; end
                end else begin
                    checks++;
                    if (st_data !== '0) begin
                        failures++; $display("FAIL st_data_idle got=%h want=0", st_data);
                    end
                end
            end
        end
        smectl_d = saved_d; st_ready = 1'b0;
        checks++;
        if (!done) begin
            failures++; $display("FAIL st_timeout got=no_done want=done");
        end
        $display("store addr=%0d de=%0d beats=%0d toggle=%0d", a, de, beats, toggle);
    endtask

    task automatic load_xfer(input logic [3:0] a, input logic [XLEN-1:0] base,
                             input bit toggle, input int flush_after);
        int de = eff(smectl_d);
        int exp_n = (de >= 2) ? de - 1 : 0;
        int beats = 0;
        int last = -1;
        bit done = 0;
        bit fl = 0;
        @(negedge g_clk);
        xfer_start = 1'b1; xfer_dir = 1'b1; xfer_addr = a; ld_valid = 1'b0;
        @(negedge g_clk);
        xfer_start = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            if (cyc > 0) @(negedge g_clk);
            if (fl) begin
                flush = 1'b0; ld_valid = 1'b0;
                #1;
                checks++;
                if (xfer_busy !== 1'b0) begin
                    failures++; $display("FAIL ld_flush_busy got=%b want=0", xfer_busy);
                end
                for (int j = 0; j < 3; j++) begin
                    checks++;
                    if (xfer_done !== 1'b0) begin
                        failures++; $display("FAIL ld_flush_done got=%b want=0", xfer_done);
                    end
                    @(negedge g_clk); #1;
                end
                $display("load addr=%0d de=%0d beats=%0d flushed", a, de, beats);
                return;
            end else if (flush_after >= 0 && beats == flush_after) begin
                flush = 1'b1; ld_valid = 1'b1; ld_data = ~base;
                #1;
                checks++;
                if (ld_ready !== 1'b1) begin
                    failures++; $display("FAIL ld_ready_at_flush got=%b want=1", ld_ready);
                end
                fl = 1;
            end else begin
                ld_valid = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
                ld_data = base ^ (32'(beats) * 32'h01010101);
                #1;
                if (xfer_done) begin
                    done = 1;
                    checks++;
                    if (beats != exp_n) begin
                        failures++; $display("FAIL ld_beats got=%0d want=%0d", beats, exp_n);
                    end
                    checks++;
                    if (cyc != last + 1) begin
                        failures++; $display("FAIL ld_done_latency got=%0d want=%0d", cyc, last + 1);
                    end
                end else begin
                    checks++;
                    if (ld_ready !== (beats < exp_n)) begin
                        failures++; $display("FAIL ld_ready beat=%0d got=%b want=%b", beats, ld_ready, beats < exp_n);
                    end
                    if (ld_valid && ld_ready) begin
                        model[beats+1][a] = ld_data;
                        beats++; last = cyc;
                    end
                end
            end
        end
        ld_valid = 1'b0; flush = 1'b0;
        checks++;
        if (!done) begin
            failures++; $display("FAIL ld_timeout got=no_done want=done");
        end
        $display("load addr=%0d de=%0d beats=%0d toggle=%0d", a, de, beats, toggle);
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({g_clk_req, xfer_busy, xfer_done, st_valid, st_last, ld_ready, clr_busy} !== 7'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b want=0", {g_clk_req, xfer_busy, xfer_done, st_valid, st_last, ld_ready, clr_busy});
        end
        checks++;
        if (st_data !== '0) begin
            failures++; $display("FAIL reset_st_data got=%h want=0", st_data);
        end
        model_zero();
        test_readback("reset");
        @(negedge g_clk);
        g_resetn = 1'b1;
        $display("reset released");
    endtask

    task automatic test_store();
        smectl_d = 4'd4;
        core_write(4'd3, {32'h33, 32'h22, 32'h11});
        checks++;
        if (model[1][3] !== 32'h11 || model[3][3] !== 32'h33) begin
            failures++; $display("FAIL store_setup got=%h want=00000011", model[1][3]);
        end
        store_xfer(4'd3, 1'b0);
    endtask

    task automatic test_load();
        smectl_d = 4'd4;
        core_write(4'd5, {32'hC3C3C3C3, 32'hB2B2B2B2, 32'h01234567});
        smectl_d = 4'd2;
        load_xfer(4'd5, 32'hA5A5A5A5, 1'b0, -1);
        @(negedge g_clk);
        rs1_addr = 4'd5;
        #1;
        checks++;
        if (rs1_shares !== {32'hC3C3C3C3, 32'hB2B2B2B2, 32'hA5A5A5A5}) begin
            failures++; $display("FAIL load_a5 got=%h want=c3c3c3c3b2b2b2b2a5a5a5a5", rs1_shares);
        end
        test_readback("load");
    endtask

    task automatic test_store_stall();
        smectl_d = 4'd4;
        core_write(4'd7, {$urandom, $urandom, $urandom});
        smectl_d = 4'd3;
        store_xfer(4'd7, 1'b1);
    endtask

    task automatic test_load_flush();
        smectl_d = 4'd4;
        core_write(4'd9, {$urandom, $urandom, $urandom});
        load_xfer(4'd9, $urandom, 1'b0, 1);
        test_readback("load_flush");
    endtask

    task automatic test_clear_priority();
        int n = 0;
        smectl_d = 4'd4;
        core_write(4'd1, {$urandom, $urandom, $urandom});
        core_write(4'd15, {$urandom, $urandom, $urandom});
        @(negedge g_clk);
        xfer_start = 1'b1; xfer_dir = 1'b0; clr_req = 1'b1;
        #1;
        checks++;
        if (g_clk_req !== 1'b1) begin
            failures++; $display("FAIL clk_req_clr got=%b want=1", g_clk_req);
        end
        @(negedge g_clk);
        xfer_start = 1'b0; clr_req = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc > 0) @(negedge g_clk);
            flush = (cyc == 2);
            xfer_start = (cyc == 3);
            #1;
            checks++;
            if (xfer_done !== 1'b0 || st_valid !== 1'b0) begin
                failures++; $display("FAIL clr_no_xfer done=%b st_valid=%b want=0", xfer_done, st_valid);
            end
            if (!clr_busy) break;
            n++;
        end
        xfer_start = 1'b0; flush = 1'b0;
        checks++;
        if (n != NREG) begin
            failures++; $display("FAIL clr_cycles got=%0d want=%0d", n, NREG);
        end
        checks++;
        if (xfer_busy !== 1'b0) begin
            failures++; $display("FAIL clr_busy_after got=%b want=0", xfer_busy);
        end
        model_zero();
        test_readback("clear");
    endtask

    task automatic test_d1();
        smectl_d = 4'd1;
        store_xfer(4'd2, 1'b0);
        smectl_d = 4'd0;
        load_xfer(4'd2, $urandom, 1'b0, -1);
    endtask

    task automatic test_wen_in_load();
        smectl_d = 4'd4;
        core_write(4'd6, {$urandom, $urandom, $urandom});
        @(negedge g_clk);
        xfer_start = 1'b1; xfer_dir = 1'b1; xfer_addr = 4'd6;
        @(negedge g_clk);
        xfer_start = 1'b0; ld_valid = 1'b0;
        rd_wen = 1'b1; rd_addr = 4'd6; rd_wdata = {$urandom, $urandom, $urandom};
        #1;
        checks++;
        if (ld_ready !== 1'b1) begin
            failures++; $display("FAIL wen_load_ready got=%b want=1", ld_ready);
        end
        @(negedge g_clk);
        rd_wen = 1'b0; flush = 1'b1;
        @(negedge g_clk);
        flush = 1'b0;
        #1;
        checks++;
        if (xfer_busy !== 1'b0 || xfer_done !== 1'b0) begin
            failures++; $display("FAIL wen_load_end busy=%b done=%b want=0", xfer_busy, xfer_done);
        end
        test_readback("wen_in_load");
    endtask

    task automatic test_reset_mid();
        smectl_d = 4'd4;
        core_write(4'd4, {$urandom, $urandom, $urandom});
        @(negedge g_clk);
        xfer_start = 1'b1; xfer_dir = 1'b0; xfer_addr = 4'd4; st_ready = 1'b0;
        @(negedge g_clk);
        xfer_start = 1'b0;
        @(negedge g_clk);
        #2;
        g_resetn = 1'b0;
        #1;
        checks++;
        if (xfer_busy !== 1'b0 || st_valid !== 1'b0 || st_data !== '0) begin
            failures++; $display("FAIL reset_mid busy=%b st_valid=%b st_data=%h want=0", xfer_busy, st_valid, st_data);
        end
        model_zero();
        @(negedge g_clk);
        g_resetn = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge g_clk); #1;
            checks++;
            if (xfer_done !== 1'b0) begin
                failures++; $display("FAIL reset_mid_done got=%b want=0", xfer_done);
            end
        end
        test_readback("reset_mid");
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            smectl_d = 4'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0, 1: core_write(4'($urandom_range(0, 15)), {$urandom, $urandom, $urandom});
                2:    store_xfer(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
                default: load_xfer(4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)), -1);
            endcase
        end
        test_readback("random");
    endtask

    initial begin
        model_zero();
        test_reset();
        test_store();
        test_load();
        test_store_stall();
        test_load_flush();
        test_clear_priority();
        test_d1();
        test_wen_in_load();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sme_share_bank.md
SME_SHARE_BANK -- requirements
Module: sme_share_bank

Interface
REQ-001 SHALL have parameter XLEN, default 32: share word width.
REQ-002 SHALL have parameter SMAX, default 4: maximum hardware shares; banks 1..SMAX-1 held here, share 0 is the GPR file.
REQ-003 SHALL have parameter NREG, default 16: registers per bank; AW = clog2(NREG).
REQ-004 SHALL have ports:
 g_clk  in  1  global clock
 g_resetn  in  1  asynchronous active-low reset
 g_clk_req  out  1  clock request
 smectl_d  in  4  shares in use (d)
 flush  in  1  abort in-progress transfer
 rs1_addr / rs2_addr  in  AW  read addresses
 rs1_shares / rs2_shares  out  (SMAX-1)*XLEN  banks 1..SMAX-1, bank k in slice k-1
 rd_wen  in  1  core write enable
 rd_addr  in  AW  core write address
 rd_wdata  in  (SMAX-1)*XLEN  core write data, same slicing
 xfer_start  in  1  begin bank transfer
 xfer_dir  in  1  0 = store (banks to stream), 1 = load (stream to banks)
 xfer_addr  in  AW  register to transfer
 xfer_busy  out  1  transfer or clear in progress
 xfer_done  out  1  one-cycle completion pulse
 st_valid / st_ready  out / in  1  store stream handshake
 st_data  out  XLEN  store word
 st_last  out  1  final store beat
 ld_valid / ld_ready  in / out  1  load stream handshake
 ld_data  in  XLEN  load word
 clr_req  in  1  zeroise all banks
 clr_busy  out  1  clear in progress

Function
REQ-005 Reads SHALL be combinational from rs1_addr/rs2_addr; writes SHALL take effect at the rising g_clk edge; a same-cycle read of a written address SHALL return the old value.
REQ-006 Effective share count de = min(smectl_d, SMAX); active banks = 1..de-1; none when de <= 1.
REQ-007 rd_wen SHALL write only active banks at rd_addr; inactive banks are unchanged.
REQ-008 FSM states: IDLE, STORE, LOAD, CLEAR; reset state IDLE.
REQ-009 IDLE: clr_req -> CLEAR (takes priority over xfer_start); else xfer_start with de >= 2 -> STORE/LOAD per xfer_dir, latching xfer_addr, de and share index k = 1.
REQ-010 xfer_start with de <= 1 in IDLE SHALL produce xfer_done the next cycle with no stream beats and no state change.
REQ-011 xfer_start and clr_req while not IDLE SHALL be ignored.
REQ-012 STORE: st_valid = 1, st_data = bank[k][addr], st_last = (k == de-1); each st_valid && st_ready increments k; the beat with st_last -> IDLE and xfer_done = 1 the following cycle.
REQ-013 LOAD: ld_ready = 1; each ld_valid && ld_ready writes ld_data to bank[k][addr] and increments k; the beat at k == de-1 -> IDLE with xfer_done the following cycle.
REQ-014 CLEAR: counter c = 0..NREG-1 zeroes register c in all SMAX-1 banks once per cycle; after c = NREG-1 -> IDLE; clr_busy = 1 throughout CLEAR; no xfer_done.
REQ-015 rd_wen SHALL be ignored in LOAD and CLEAR; in STORE, core writes proceed and stored words reflect the value at each beat.
REQ-016 flush in STORE or LOAD -> IDLE next cycle, no xfer_done, already-loaded shares kept; flush SHALL NOT affect CLEAR.
REQ-017 smectl_d changes during a transfer SHALL NOT affect it (latched de used).
REQ-018 st_valid, st_last and ld_ready SHALL be 0 outside STORE/LOAD; st_data = 0 when st_valid = 0.
REQ-019 xfer_busy = (state != IDLE); g_clk_req = xfer_busy || rd_wen || xfer_start || clr_req.

Reset
REQ-020 g_resetn low SHALL asynchronously force IDLE, k = c = 0, all bank registers to 0, and all outputs low/zero.
REQ-021 Reset asserted mid-transfer or mid-clear SHALL abort it with no xfer_done.

Verification
REQ-022 smectl_d=4, rd_wen addr 3 data {0x33,0x22,0x11} (banks 3,2,1), store addr 3, st_ready=1 -> beats 0x11,0x22,0x33, st_last on third, xfer_done one cycle later.
REQ-023 smectl_d=2, load addr 5 with ld_data 0xA5A5A5A5 -> one beat, bank1[5]=0xA5A5A5A5, banks 2-3 unchanged, xfer_done next cycle.
REQ-024 Store with st_ready toggled 0/1 each cycle, smectl_d=3 -> exactly 2 beats, st_data held while stalled.
REQ-025 Load at smectl_d=4, flush after first beat -> IDLE, bank1 written, banks 2-3 unchanged, no xfer_done; simultaneous xfer_start+clr_req -> CLEAR wins, NREG cycles, all registers read 0.
REQ-026 smectl_d=1, xfer_start -> xfer_done next cycle, zero beats; rd_wen during LOAD -> no write observed.
